// File: rtl/q_fwd_pipe_sink.sv
// FIFO sink for a forward-pipelined link. An item accepted at edge t is visible at o_d/o_v after t.
// i_b is registered and asserts while `reserve` slots remain, so items already in the pipe still land.
// Optional sticky overflow flag: define Q_FWD_PIPE_SINK_OVF_EN.
module q_fwd_pipe_sink #(
  parameter int depth     = 8,
  parameter int width     = 16,
  parameter int reserve   = 2,
  parameter int addrwidth = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [width-1:0] i_d,
  input  logic             i_v,
  output logic             i_b,
  output logic [width-1:0] o_d,
  output logic             o_v,
`ifdef Q_FWD_PIPE_SINK_OVF_EN
  input  logic             o_b,
  output logic             ovf
`else
  input  logic             o_b
`endif
);

  localparam int AW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = addrwidth + 1;

  localparam logic [CW-1:0] DEPTH_C  = CW'(depth);
  localparam logic [CW-1:0] THRESH_C = CW'(depth - reserve);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_LAST = AW'(depth - 1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [width-1:0] mem_q [depth];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             i_b_q, i_b_d;
  logic             enq, deq;

  assign o_v = (count_q != '0);
  assign o_d = mem_q[rd_ptr_q];
  assign i_b = i_b_q;

  always_comb begin
    deq      = o_v & ~o_b;
    // A full FIFO still accepts when the head leaves in the same cycle.
    enq      = i_v & ((count_q < DEPTH_C) | deq);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
    if (deq) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
    if (enq && !deq)      count_d = count_q + CNT_ONE;
    else if (!enq && deq) count_d = count_q - CNT_ONE;
    // Based on next count so the flag carries no extra cycle of lag.
    i_b_d    = (count_d >= THRESH_C);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      i_b_q    <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      i_b_q    <= i_b_d;
    end
  end

  always_ff @(posedge clock) begin
    if (enq) mem_q[wr_ptr_q] <= i_d;
  end

`ifdef Q_FWD_PIPE_SINK_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q | (i_v & ~enq);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_q_fwd_pipe_sink.sv
// Bench for q_fwd_pipe_sink (depth=8, width=16, reserve=2): vector table plus
// a scoreboard queue holding the expected FIFO contents.
module tb_q_fwd_pipe_sink;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] i_d   = '0;
  logic        i_v   = 1'b0;
  logic        o_b   = 1'b0;
  logic        i_b;
  logic        o_v;
  logic [15:0] o_d;
`ifdef Q_FWD_PIPE_SINK_OVF_EN
  logic        ovf;
`endif

  q_fwd_pipe_sink #(.depth(8), .width(16), .reserve(2), .addrwidth(8)) dut (
    .clock(clock),
    .reset(reset),
    .i_d  (i_d),
    .i_v  (i_v),
    .i_b  (i_b),
    .o_d  (o_d),
    .o_v  (o_v),
`ifdef Q_FWD_PIPE_SINK_OVF_EN
    .o_b  (o_b),
    .ovf  (ovf)
`else
    .o_b  (o_b)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        iv;
    logic [15:0] id;
    logic        ob;
    logic        exp_ov;
    logic        exp_ib;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] sb[$];
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic void add(input logic iv, input logic [15:0] id, input logic ob,
                              input logic ov, input logic ib);
    vec_t v;
    v.iv = iv; v.id = id; v.ob = ob; v.exp_ov = ov; v.exp_ib = ib;
    vecs.push_back(v);
  endfunction

  // Entered 1 time unit after a rising edge; leaves 1 time unit after the next one.
  task automatic cycle(input logic iv, input logic [15:0] id, input logic ob);
    logic deq_m, enq_m;
    i_v = iv; i_d = id; o_b = ob;
    #1;
    deq_m = (sb.size() != 0) && !ob;
    enq_m = iv && ((sb.size() < 8) || deq_m);
    if (deq_m) begin
      chk("o_d_head", {16'h0, o_d}, {16'h0, sb[0]});
      void'(sb.pop_front());
    end
    if (enq_m) sb.push_back(id);
    @(posedge clock);
    #1;
    chk("o_v_sb", {31'h0, o_v}, {31'h0, sb.size() != 0});
    chk("i_b_sb", {31'h0, i_b}, {31'h0, sb.size() >= 6});
  endtask

  initial begin
    add(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 16'h00A5, 1'b0, 1'b1, 1'b0);
    add(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) add(1'b1, 16'(k), 1'b1, 1'b1, k >= 6);
    add(1'b1, 16'hDEAD, 1'b1, 1'b1, 1'b1);
    for (int k = 1; k <= 8; k++) add(1'b0, 16'h0, 1'b0, (8 - k) != 0, (8 - k) >= 6);
    for (int k = 1; k <= 8; k++) add(1'b1, 16'(k), 1'b1, 1'b1, k >= 6);
    add(1'b1, 16'h0009, 1'b0, 1'b1, 1'b1);
    for (int k = 1; k <= 8; k++) add(1'b0, 16'h0, 1'b0, (8 - k) != 0, (8 - k) >= 6);

    repeat (2) @(posedge clock);
    #1;
    chk("rst_i_b", {31'h0, i_b}, 32'h1);
    chk("rst_o_v", {31'h0, o_v}, 32'h0);
`ifdef Q_FWD_PIPE_SINK_OVF_EN
    chk("rst_ovf", {31'h0, ovf}, 32'h0);
`endif
    reset = 1'b1;
    #1;
    chk("rel_i_b_before_edge", {31'h0, i_b}, 32'h1);

    foreach (vecs[n]) begin
      cycle(vecs[n].iv, vecs[n].id, vecs[n].ob);
      chk($sformatf("tbl_o_v[%0d]", n), {31'h0, o_v}, {31'h0, vecs[n].exp_ov});
      chk($sformatf("tbl_i_b[%0d]", n), {31'h0, i_b}, {31'h0, vecs[n].exp_ib});
    end
`ifdef Q_FWD_PIPE_SINK_OVF_EN
    chk("ovf_sticky", {31'h0, ovf}, 32'h1);
`endif

    // Reset in the middle of a cycle with five items stored.
    for (int k = 1; k <= 5; k++) cycle(1'b1, 16'(16'h0100 + k), 1'b1);
    chk("mid_cnt5_o_v", {31'h0, o_v}, 32'h1);
    #3;
    reset = 1'b0;
    #1;
    chk("mid_rst_o_v", {31'h0, o_v}, 32'h0);
    chk("mid_rst_i_b", {31'h0, i_b}, 32'h1);
`ifdef Q_FWD_PIPE_SINK_OVF_EN
    chk("mid_rst_ovf", {31'h0, ovf}, 32'h0);
`endif
    sb.delete();
    i_v = 1'b1; i_d = 16'hBEEF; o_b = 1'b0;
    @(posedge clock);
    #1;
    chk("rst_iv_ignored", {31'h0, o_v}, 32'h0);
    reset = 1'b1;
    cycle(1'b0, 16'h0, 1'b0);
    chk("post_rst_empty", {31'h0, o_v}, 32'h0);
    chk("post_rst_i_b", {31'h0, i_b}, 32'h0);
    cycle(1'b1, 16'h0077, 1'b0);
    chk("post_rst_push", {16'h0, o_d}, 32'h0077);
    cycle(1'b0, 16'h0, 1'b0);
    chk("post_rst_drained", {31'h0, o_v}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
